// File: rtl/dct_pkg.sv
// rtl/dct_pkg.sv - shared widths, types and saturation helper for the 2D DCT controller
package dct_pkg;

  localparam int N  = 8;
  localparam int XW = 9;
  localparam int YW = 18;

  typedef logic signed [XW-1:0] samp_t;
  typedef logic signed [YW-1:0] coef_t;

  typedef enum logic {ST_ROW, ST_COL} dct_state_t;

  function automatic samp_t sat9(input logic signed [18:0] v);
    if (v > 19'sd255) begin
      return 9'sd255;
    end else if (v < -19'sd256) begin
      return -9'sd256;
    end
    return samp_t'(v[XW-1:0]);
  endfunction

endpackage

// File: rtl/dct_tbuf.sv
// rtl/dct_tbuf.sv - 8x8 transpose buffer, whole-row write port and whole-column read port
module dct_tbuf
  import dct_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [2:0]        wr_row,
  input  logic [N*XW-1:0]   wr_data,
  input  logic [2:0]        rd_col,
  output logic [N*XW-1:0]   rd_data
);

  samp_t mem_q [N][N];
  samp_t mem_d [N][N];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      for (int c = 0; c < N; c++) begin
        mem_d[wr_row][c] = samp_t'(wr_data[c*XW +: XW]);
      end
    end
  end

  // Element r of the read column comes from row r, which is the transpose.
  always_comb begin
    rd_data = '0;
    for (int r = 0; r < N; r++) begin
      rd_data[r*XW +: XW] = mem_q[r][rd_col];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          mem_q[r][c] <= '0;
        end
      end
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/dct2d_ctrl.sv
// rtl/dct2d_ctrl.sv - row pass / transpose / column pass sequencer around one shared fastDCT8
module dct2d_ctrl
  import dct_pkg::*;
#(
  parameter int ROW_SHIFT = 3,
  parameter bit ROUND     = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N*XW-1:0]   in_row,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N*YW-1:0]   out_col,
  output logic [2:0]        out_idx,
  output logic              blk_done,
  output logic [N*XW-1:0]   dct_x,
  input  logic [N*YW-1:0]   dct_y
);

  localparam logic signed [18:0] RND_ADD = ROUND ? 19'(1 << (ROW_SHIFT-1)) : 19'd0;

  dct_state_t         state_q, state_d;
  logic [2:0]         row_cnt_q, row_cnt_d;
  logic [3:0]         col_cnt_q, col_cnt_d;
  logic               out_valid_q, out_valid_d;
  logic [N*YW-1:0]    out_col_q, out_col_d;
  logic [2:0]         out_idx_q, out_idx_d;
  logic               blk_done_q, blk_done_d;
  logic               tb_wr;
  logic [N*XW-1:0]    tb_wr_data;
  logic [N*XW-1:0]    tb_rd_data;
  logic signed [18:0] acc;

  dct_tbuf u_tbuf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (tb_wr),
    .wr_row  (row_cnt_q),
    .wr_data (tb_wr_data),
    .rd_col  (col_cnt_q[2:0]),
    .rd_data (tb_rd_data)
  );

  assign in_ready  = (state_q == ST_ROW);
  assign dct_x     = (state_q == ST_ROW) ? in_row : tb_rd_data;
  assign out_valid = out_valid_q;
  assign out_col   = out_col_q;
  assign out_idx   = out_idx_q;
  assign blk_done  = blk_done_q;

  // Row-pass scaling: sign-extend to 19 bits so the rounding add cannot wrap.
  always_comb begin
    tb_wr_data = '0;
    acc        = '0;
    for (int i = 0; i < N; i++) begin
      acc = {dct_y[i*YW+YW-1], dct_y[i*YW +: YW]};
      acc = acc + RND_ADD;
      acc = acc >>> ROW_SHIFT;
      tb_wr_data[i*XW +: XW] = sat9(acc);
    end
  end

  always_comb begin
    state_d     = state_q;
    row_cnt_d   = row_cnt_q;
    col_cnt_d   = col_cnt_q;
    out_valid_d = out_valid_q;
    out_col_d   = out_col_q;
    out_idx_d   = out_idx_q;
    blk_done_d  = 1'b0;
    tb_wr       = 1'b0;
    case (state_q)
      ST_ROW: begin
        if (in_valid) begin
          tb_wr     = 1'b1;
          row_cnt_d = row_cnt_q + 3'd1;
          if (row_cnt_q == 3'd7) begin
            state_d   = ST_COL;
            col_cnt_d = '0;
          end
        end
      end
      ST_COL: begin
        if (!col_cnt_q[3] && (!out_valid_q || out_ready)) begin
          out_col_d   = dct_y;
          out_idx_d   = col_cnt_q[2:0];
          out_valid_d = 1'b1;
          col_cnt_d   = col_cnt_q + 4'd1;
        end else if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
        end
        // Leaving COL only on the last handshake keeps in_ready low in that cycle.
        if (out_valid_q && out_ready && out_idx_q == 3'd7) begin
          blk_done_d = 1'b1;
          state_d    = ST_ROW;
          row_cnt_d  = '0;
        end
      end
      default: state_d = ST_ROW;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_ROW;
      row_cnt_q   <= '0;
      col_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_col_q   <= '0;
      out_idx_q   <= '0;
      blk_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      col_cnt_q   <= col_cnt_d;
      out_valid_q <= out_valid_d;
      out_col_q   <= out_col_d;
      out_idx_q   <= out_idx_d;
      blk_done_q  <= blk_done_d;
    end
  end

endmodule

// File: tb/tb_dct2d_ctrl.sv
// tb/tb_dct2d_ctrl.sv - scoreboard bench for dct2d_ctrl with a stub fastDCT8 core
module tb_dct2d_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [71:0]  in_row;
  logic         out_valid;
  logic         out_ready;
  logic [143:0] out_col;
  logic [2:0]   out_idx;
  logic         blk_done;
  logic [71:0]  dct_x;
  logic [143:0] dct_y;

  int stub_mode = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int blk_cnt = 0;
  int nready = 0;
  int stall_cnt = 0;
  int stall_left = 0;
  bit stall_req = 1'b0;
  bit stall_done = 1'b0;
  int rows [8][8];
  int base [8] = '{53, -33, 20, 22, 56, 100, -107, 85};

  logic [2:0]   exp_idx_q [$];
  logic [143:0] exp_col_q [$];
  logic [2:0]   e_idx;
  logic [143:0] e_col;

  always #5 clk = ~clk;

  dct2d_ctrl #(.ROW_SHIFT(3), .ROUND(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_row    (in_row),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_col   (out_col),
    .out_idx   (out_idx),
    .blk_done  (blk_done),
    .dct_x     (dct_x),
    .dct_y     (dct_y)
  );

  // Stub cores: 0 -> x*8, 1 -> x*16, 2 -> 3*x[i] - x[i+1] (mixes neighbouring lanes)
  function automatic int core_i(int m, int a, int b);
    case (m)
      0:       return 8 * a;
      1:       return 16 * a;
      default: return 3 * a - b;
    endcase
  endfunction

  function automatic logic [143:0] core(logic [71:0] x, int m);
    logic [143:0] y;
    int a, b;
    y = '0;
    for (int i = 0; i < 8; i++) begin
      a = int'($signed(x[i*9 +: 9]));
      b = int'($signed(x[((i+1)%8)*9 +: 9]));
      y[i*18 +: 18] = 18'(core_i(m, a, b));
    end
    return y;
  endfunction

  assign dct_y = core(dct_x, stub_mode);

  task automatic chk(string name, logic [143:0] act, logic [143:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (!in_ready) nready++;
      if (out_valid && !out_ready) stall_cnt++;
      if (blk_done) blk_cnt++;
      if (out_valid && out_ready) begin
        if (exp_idx_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_col: got idx %0d expected no column", out_idx);
        end else begin
          e_idx = exp_idx_q.pop_front();
          e_col = exp_col_q.pop_front();
          chk("out_idx", 144'(out_idx), 144'(e_idx));
          chk("out_col", out_col, e_col);
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (stall_left > 0) begin
      stall_left--;
      if (stall_left == 0) out_ready = 1'b1;
    end else if (stall_req && !stall_done && out_valid && out_idx == 3'd3) begin
      out_ready  = 1'b0;
      stall_left = 5;
      stall_done = 1'b1;
    end
  end

  task automatic push_transpose();
    logic [143:0] c;
    for (int k = 0; k < 8; k++) begin
      c = '0;
      for (int i = 0; i < 8; i++) c[i*18 +: 18] = 18'(8 * (8*i + k - 32));
      exp_idx_q.push_back(3'(k));
      exp_col_q.push_back(c);
    end
  endtask

  task automatic push_const(int v);
    logic [143:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) c[i*18 +: 18] = 18'(v);
    for (int k = 0; k < 8; k++) begin
      exp_idx_q.push_back(3'(k));
      exp_col_q.push_back(c);
    end
  endtask

  task automatic push_model(int m);
    int t [8][8];
    int v;
    logic [143:0] c;
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 8; i++) begin
        v = (core_i(m, rows[r][i], rows[r][(i+1)%8]) + 4) >>> 3;
        t[r][i] = (v > 255) ? 255 : ((v < -256) ? -256 : v);
      end
    end
    for (int k = 0; k < 8; k++) begin
      c = '0;
      for (int i = 0; i < 8; i++) c[i*18 +: 18] = 18'(core_i(m, t[i][k], t[(i+1)%8][k]));
      exp_idx_q.push_back(3'(k));
      exp_col_q.push_back(c);
    end
  endtask

  task automatic fill_transpose();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) rows[r][c] = 8*r + c - 32;
  endtask

  task automatic fill_const(int v);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) rows[r][c] = v;
  endtask

  task automatic fill_perm(int off);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) rows[r][c] = base[(c + r + off) % 8];
  endtask

  task automatic send_rows(int nrows, bit toggle);
    int r = 0;
    int budget = 0;
    bit ph = 1'b1;
    while (r < nrows && budget < 200) begin
      @(negedge clk);
      budget++;
      for (int c = 0; c < 8; c++) in_row[c*9 +: 9] = 9'(rows[r][c]);
      in_valid = toggle ? ph : 1'b1;
      ph = ~ph;
      if (in_valid && in_ready) r++;
    end
    chk("rows_accepted", 144'(r), 144'(nrows));
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_blk(int target);
    int budget = 0;
    while (blk_cnt < target && budget < 300) begin
      @(negedge clk);
      #1;
      budget++;
    end
    chk("blk_cnt", 144'(blk_cnt), 144'(target));
  endtask

  task automatic check_reset();
    chk("rst_out_valid", 144'(out_valid), 144'(0));
    chk("rst_out_idx", 144'(out_idx), 144'(0));
    chk("rst_out_col", out_col, 144'(0));
    chk("rst_blk_done", 144'(blk_done), 144'(0));
    chk("rst_in_ready", 144'(in_ready), 144'(1));
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_row    = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_reset();
    rst = 1'b0;

    // transpose ordering, continuous input
    stub_mode = 0;
    fill_transpose();
    push_transpose();
    nready = 0;
    send_rows(8, 1'b0);
    idle();
    wait_blk(1);
    chk("in_ready_low_cycles", 144'(nready), 144'(9));

    // saturation, with a 5-cycle output stall at column 3
    stub_mode = 1;
    fill_const(200);
    push_const(4080);
    nready = 0;
    stall_cnt = 0;
    stall_done = 1'b0;
    stall_req = 1'b1;
    send_rows(8, 1'b0);
    idle();
    wait_blk(2);
    stall_req = 1'b0;
    chk("stall_cycles", 144'(stall_cnt), 144'(5));
    chk("in_ready_low_stall", 144'(nready), 144'(14));

    // input valid toggling every cycle
    stub_mode = 0;
    fill_transpose();
    push_transpose();
    nready = 0;
    send_rows(8, 1'b1);
    idle();
    wait_blk(3);
    chk("in_ready_low_toggle", 144'(nready), 144'(9));

    // reset after a partial block, then a clean block
    send_rows(4, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_reset();
    @(negedge clk);
    rst = 1'b0;
    push_transpose();
    send_rows(8, 1'b0);
    idle();
    wait_blk(4);

    // three blocks back to back through the mixing core
    stub_mode = 2;
    for (int b = 0; b < 3; b++) begin
      fill_perm(b);
      push_model(2);
      send_rows(8, 1'b0);
    end
    idle();
    wait_blk(7);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 144'(exp_idx_q.size()), 144'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
